// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with hold-time limit.
// A grant lasts until the owner signals done, drops its request, or has held
// the resource for MAX_HOLD cycles. Each grant is followed by one GAP cycle
// and one IDLE cycle before the next arbitration. All outputs are registered.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_SAT   = 8'hFF;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    logic [2:0] winner;
    logic [2:0] cand;
    logic       any_req;
    logic       exit_done;
    logic       exit_drop;
    logic       exit_hold;

    function automatic logic [7:0] decode3(input logic [2:0] idx);
        decode3 = 8'b0000_0001 << idx;
    endfunction

    // Release reasons for the current owner, in priority order.
    assign exit_done = done;
    assign exit_drop = ~req[gnt_idx_q];
    assign exit_hold = (hold_cnt_q == HOLD_LIMIT);

    // Rotating priority search: the lowest offset from ptr with a request wins.
    always_comb begin
        winner  = ptr_q;
        any_req = 1'b0;
        cand    = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr_q + 3'(k);
            if (req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; timeout only pulses on a pure hold expiry.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = winner;
                    gnt_d       = decode3(winner);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd1;
                end
            end
            ST_GRANT: begin
                if (exit_done || exit_drop || exit_hold) begin
                    state_d     = ST_GAP;
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 3'd1;
                    timeout_d   = exit_hold & ~exit_done & ~exit_drop;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: the stimulus side runs a behavioural
// model and queues the expected outputs; a monitor pops and compares them
// after every rising edge.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: owner is -1 when nobody holds the resource.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [7:0] q, input logic d);
        bit a, b, c;
        int w;
        if (!r) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_gap = 1'b0; m_to = 1'b0;
        end else if (m_owner >= 0) begin
            a = d;
            b = !q[m_owner];
            c = (m_hold == MAX_HOLD);
            if (a || b || c) begin
                m_to    = c && !a && !b;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_to = 1'b0;
                if (m_hold < 255) m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_to  = 1'b0;
        end else begin
            m_to = 1'b0;
            w = rr_pick(q, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_hold  = 1;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [7:0] q, input logic d);
        exp_t e;
        rst_n = r;
        req   = q;
        done  = d;
        model_step(r, q, d);
        e.gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        e.idx = 3'(m_last);
        e.vld = (m_owner >= 0);
        e.to  = m_to;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare every registered output one time unit after each edge.
    initial begin
        exp_t e;
        logic prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",       32'(gnt),       32'(e.gnt));
                chk("gnt_idx",   32'(gnt_idx),   32'(e.idx));
                chk("gnt_valid", 32'(gnt_valid), 32'(e.vld));
                chk("timeout",   32'(timeout),   32'(e.to));
                chk("onehot0",   32'($onehot0(gnt)), 32'd1);
            end
            if (gnt_valid === 1'b1 && !prev_vld) grant_log.push_back(int'(gnt_idx));
            prev_vld = (gnt_valid === 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and idle with no requests.
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        repeat (3) cycle(1'b1, 8'h00, 1'b0);

        // Two requesters: idx 2 first, then idx 5 after a done pulse.
        grant_log.delete();
        repeat (3) cycle(1'b1, 8'b0010_0100, 1'b0);
        cycle(1'b1, 8'b0010_0100, 1'b1);
        repeat (5) cycle(1'b1, 8'b0010_0100, 1'b0);
        chk("two_req_first",  32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd2);
        chk("two_req_second", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd5);

        // All requesting, done on the second grant cycle: order 0..7 then 0.
        cycle(1'b0, 8'h00, 1'b0);
        grant_log.delete();
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'hFF, (m_owner >= 0 && m_hold == 2));
        for (int i = 0; i < 9; i++)
            chk("fair_order", 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(i % 8));

        // Single persistent requester with no done: repeated hold expiry.
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'b0000_1000, 1'b0);

        // Owner 3 drops its request: no timeout, next search starts at 4.
        cycle(1'b0, 8'h00, 1'b0);
        repeat (2) cycle(1'b1, 8'b0000_1000, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        grant_log.delete();
        repeat (6) cycle(1'b1, 8'hFF, 1'b0);
        chk("ptr_after_drop", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd4);

        // Reset while idx 6 holds the grant, then idx 0 wins.
        cycle(1'b0, 8'h00, 1'b0);
        repeat (3) cycle(1'b1, 8'b0100_0000, 1'b0);
        cycle(1'b0, 8'b0100_0000, 1'b0);
        grant_log.delete();
        repeat (3) cycle(1'b1, 8'b0100_0001, 1'b0);
        chk("after_reset_win", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

        // done coinciding with hold expiry must not raise timeout.
        for (int i = 0; i < 24; i++)
            cycle(1'b1, 8'b0000_1000, (m_owner >= 0 && m_hold == MAX_HOLD));

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
            cycle(($urandom_range(0, 99) != 0), r, ($urandom_range(0, 3) == 0));
        end

        repeat (2) cycle(1'b1, 8'h00, 1'b0);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
